// File: rtl/rmii_rx_frame.sv
// RMII receive front-end: samples LAN8720 pins on clk_mac, strips preamble/SFD/FCS,
// checks CRC-32 and length, and streams DA..last payload byte with per-frame status.
module rmii_rx_frame #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int MIN_PRE = 4
) (
  input  logic       clk_mac,
  input  logic       rst,
  input  logic       eth_crsdv,
  input  logic [1:0] eth_rxd,
  input  logic       eth_rxerr,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  output logic       m_err,
  output logic       stat_ok,
  output logic       stat_bad
);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    PRE       = 2'd2,
    DATA      = 2'd3
  } state_t;

  localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
  localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);
  localparam logic [10:0] MAX_P1_C  = 11'(MAX_LEN + 1);
  localparam logic [3:0]  MIN_PRE_C = 4'(MIN_PRE);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB88320;
      else                c = c >> 1;
    end
    return c;
  endfunction

  state_t          state_r;
  logic            crsdv_r, crsdv_d_r, rxerr_r, rxerr_seen_r;
  logic [1:0]      rxd_r, dcnt_r;
  logic [3:0]      pre_cnt_r;
  logic [5:0]      sh_r;
  logic [10:0]     n_r;
  logic [31:0]     crc_r;
  logic [4:0][7:0] dl_r;

  logic        carrier_end_s, close_ovf_s, close_s, close_err_s;
  logic [7:0]  byte_s;
  logic [10:0] n_inc_s;
  logic [31:0] crc_next_s;

  assign carrier_end_s = !crsdv_r && !crsdv_d_r;
  assign byte_s        = {rxd_r, sh_r};
  assign n_inc_s       = (n_r == 11'd2047) ? n_r : n_r + 11'd1;
  assign crc_next_s    = crc32_byte(crc_r, byte_s);
  assign close_ovf_s   = (state_r == DATA) && (n_r == MAX_P1_C);
  assign close_s       = close_ovf_s || ((state_r == DATA) && carrier_end_s);
  // The first low crsdv cycle of a true carrier end was taken as a dibit, so a
  // well-formed frame closes with exactly one stray dibit in the partial byte.
  assign close_err_s   = (crc_r != CRC_RESIDUE) || rxerr_seen_r || rxerr_r ||
                         (n_r < MIN_LEN_C) || (n_r > MAX_LEN_C) ||
                         (!close_ovf_s && (dcnt_r != 2'd1));

  // Input capture, framing state machine, delay line, CRC and registered outputs.
  always_ff @(posedge clk_mac or posedge rst) begin
    if (rst) begin
      crsdv_r      <= 1'b1;
      crsdv_d_r    <= 1'b1;
      rxd_r        <= 2'd0;
      rxerr_r      <= 1'b0;
      state_r      <= WAIT_IDLE;
      pre_cnt_r    <= 4'd0;
      dcnt_r       <= 2'd0;
      sh_r         <= 6'd0;
      n_r          <= 11'd0;
      crc_r        <= 32'hFFFFFFFF;
      rxerr_seen_r <= 1'b0;
      dl_r         <= 40'd0;
      m_data       <= 8'd0;
      m_valid      <= 1'b0;
      m_last       <= 1'b0;
      m_err        <= 1'b0;
      stat_ok      <= 1'b0;
      stat_bad     <= 1'b0;
    end else begin
      crsdv_r   <= eth_crsdv;
      crsdv_d_r <= crsdv_r;
      rxd_r     <= eth_rxd;
      rxerr_r   <= eth_rxerr;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_err     <= 1'b0;
      stat_ok   <= 1'b0;
      stat_bad  <= 1'b0;
      case (state_r)
        WAIT_IDLE: begin
          if (carrier_end_s) state_r <= IDLE;
        end
        IDLE: begin
          if (crsdv_r && (rxd_r == 2'b01)) begin
            state_r   <= PRE;
            pre_cnt_r <= 4'd1;
          end
        end
        PRE: begin
          if (carrier_end_s) begin
            state_r <= IDLE;
          end else begin
            case (rxd_r)
              2'b01: begin
                if (pre_cnt_r != 4'd15) pre_cnt_r <= pre_cnt_r + 4'd1;
              end
              2'b11: begin
                if (pre_cnt_r >= MIN_PRE_C) begin
                  state_r      <= DATA;
                  n_r          <= 11'd0;
                  dcnt_r       <= 2'd0;
                  crc_r        <= 32'hFFFFFFFF;
                  rxerr_seen_r <= 1'b0;
                end else begin
                  state_r <= WAIT_IDLE;
                end
              end
              default: state_r <= WAIT_IDLE;
            endcase
          end
        end
        DATA: begin
          if (close_s) begin
            state_r  <= close_ovf_s ? WAIT_IDLE : IDLE;
            stat_ok  <= !close_err_s;
            stat_bad <= close_err_s;
            if (n_r >= 11'd5) begin
              m_valid <= 1'b1;
              m_last  <= 1'b1;
              m_err   <= close_err_s;
              m_data  <= dl_r[4];
            end
          end else begin
            rxerr_seen_r <= rxerr_seen_r | rxerr_r;
            dcnt_r       <= dcnt_r + 2'd1;
            sh_r         <= {rxd_r, sh_r[5:2]};
            if (dcnt_r == 2'd3) begin
              n_r   <= n_inc_s;
              crc_r <= crc_next_s;
              dl_r  <= {dl_r[3:0], byte_s};
              if (n_r >= 11'd5) begin
                m_valid <= 1'b1;
                m_data  <= dl_r[4];
              end
            end
          end
        end
        default: state_r <= WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rmii_rx_frame.sv
// Directed-vector bench for rmii_rx_frame: stimulus pushes expected bytes/status into
// queues, a forked monitor pops and compares whenever the DUT presents an output.
module tb_rmii_rx_frame;

  logic       clk_mac = 1'b0;
  logic       rst;
  logic       eth_crsdv;
  logic [1:0] eth_rxd;
  logic       eth_rxerr;
  logic [7:0] m_data;
  logic       m_valid, m_last, m_err, stat_ok, stat_bad;

  rmii_rx_frame dut (
    .clk_mac  (clk_mac),
    .rst      (rst),
    .eth_crsdv(eth_crsdv),
    .eth_rxd  (eth_rxd),
    .eth_rxerr(eth_rxerr),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_last   (m_last),
    .m_err    (m_err),
    .stat_ok  (stat_ok),
    .stat_bad (stat_bad)
  );

  always #10 clk_mac = ~clk_mac;

  typedef struct packed { logic [7:0] data; logic last; logic err; } exp_t;
  typedef struct packed { logic ok; logic with_last; } st_t;

  exp_t       exp_q[$];
  st_t        st_q[$];
  logic [7:0] tx_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  bit         done = 1'b0;

  function automatic logic [31:0] ref_crc(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic drive(input logic c, input logic [1:0] d, input logic e);
    eth_crsdv = c;
    eth_rxd   = d;
    eth_rxerr = e;
    @(negedge clk_mac);
  endtask

  // Payload bytes 00,01,..., optionally followed by the FCS (complemented CRC, LSB first).
  task automatic build_frame(input int len, input bit add_fcs);
    logic [31:0] crc;
    tx_q.delete();
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++) begin
      tx_q.push_back(i[7:0]);
      crc = ref_crc(crc, i[7:0]);
    end
    if (add_fcs) begin
      crc = ~crc;
      for (int k = 0; k < 4; k++) tx_q.push_back(crc[8*k +: 8]);
    end
  endtask

  // Bytes 0..cnt-5 come out; cnt is capped where the oversize cut closes the frame.
  task automatic expect_frame(input bit bad);
    int cnt;
    cnt = (tx_q.size() > 1519) ? 1519 : tx_q.size();
    for (int k = 0; k <= cnt - 5; k++)
      exp_q.push_back({tx_q[k], (k == cnt - 5), (bad && (k == cnt - 5))});
    st_q.push_back({!bad, (cnt >= 5)});
  endtask

  task automatic send_frame(input int npre, input int err_dibit, input bit toggle,
                            input int extra, input int rst_byte, input int ipg);
    logic [7:0] b;
    int n, di;
    n = tx_q.size();
    for (int p = 0; p < npre; p++) drive(1'b1, 2'b01, 1'b0);
    drive(1'b1, 2'b11, 1'b0);
    for (int i = 0; i < n; i++) begin
      b = tx_q[i];
      for (int j = 0; j < 4; j++) begin
        di = i * 4 + j;
        if (i == rst_byte && j == 2) begin
          rst = 1'b1;
          #1;
          chk("rst_mid_m_data", {24'd0, m_data}, 32'd0);
          chk("rst_mid_flags", {27'd0, m_valid, m_last, m_err, stat_ok, stat_bad}, 32'd0);
        end
        if (i == rst_byte + 1 && j == 2) rst = 1'b0;
        drive(!(toggle && (i >= n - 4) && (di % 8 == 0)), b[2*j +: 2], (di == err_dibit));
      end
    end
    for (int x = 0; x < extra; x++) drive(1'b1, 2'b10, 1'b0);
    for (int x = 0; x < ipg; x++) drive(1'b0, 2'b00, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    for (int c = 0; c < 200 && (exp_q.size() != 0 || st_q.size() != 0); c++) @(negedge clk_mac);
    for (int c = 0; c < 4; c++) @(negedge clk_mac);
    chk(name, exp_q.size() + st_q.size(), 0);
  endtask

  initial begin
    rst       = 1'b1;
    eth_crsdv = 1'b0;
    eth_rxd   = 2'b00;
    eth_rxerr = 1'b0;
    fork
      begin : monitor
        exp_t e;
        st_t  s;
        while (!done) begin
          @(negedge clk_mac);
          if (m_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++;
              $display("FAIL unexpected_byte: got data=%02h last=%0b, required no byte", m_data, m_last);
            end else begin
              e = exp_q.pop_front();
              if ({m_data, m_last, m_err} !== {e.data, e.last, e.err}) begin
                miscompares++;
                $display("FAIL byte: got data=%02h last=%0b err=%0b, required data=%02h last=%0b err=%0b",
                         m_data, m_last, m_err, e.data, e.last, e.err);
              end
            end
          end else if (m_last || m_err) begin
            vectors++;
            miscompares++;
            $display("FAIL qualifier: got m_last=%0b m_err=%0b without m_valid, required 0", m_last, m_err);
          end
          if (stat_ok || stat_bad) begin
            vectors++;
            if (st_q.size() == 0) begin
              miscompares++;
              $display("FAIL unexpected_stat: got ok=%0b bad=%0b, required none", stat_ok, stat_bad);
            end else begin
              s = st_q.pop_front();
              if ({stat_ok, stat_bad, m_last} !== {s.ok, !s.ok, s.with_last}) begin
                miscompares++;
                $display("FAIL stat: got ok=%0b bad=%0b last=%0b, required ok=%0b bad=%0b last=%0b",
                         stat_ok, stat_bad, m_last, s.ok, !s.ok, s.with_last);
              end
            end
          end
        end
      end
      begin : stimulus
        repeat (3) @(negedge clk_mac);
        chk("reset_m_data", {24'd0, m_data}, 32'd0);
        chk("reset_m_valid", {31'd0, m_valid}, 32'd0);
        chk("reset_m_last", {31'd0, m_last}, 32'd0);
        chk("reset_m_err", {31'd0, m_err}, 32'd0);
        chk("reset_stat_ok", {31'd0, stat_ok}, 32'd0);
        chk("reset_stat_bad", {31'd0, stat_bad}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk_mac);

        build_frame(60, 1'b1); expect_frame(1'b0);
        send_frame(31, -1, 1'b0, 0, -1, 6); wait_drain("good_frame");

        build_frame(60, 1'b1); tx_q[10] = tx_q[10] ^ 8'h01; expect_frame(1'b1);
        send_frame(31, -1, 1'b0, 0, -1, 6); wait_drain("corrupt_fcs");

        build_frame(60, 1'b1); expect_frame(1'b1);
        send_frame(31, 100, 1'b0, 0, -1, 6); wait_drain("rxerr");

        build_frame(60, 1'b1); expect_frame(1'b1);
        send_frame(31, -1, 1'b0, 2, -1, 6); wait_drain("extra_dibits");

        build_frame(36, 1'b1); expect_frame(1'b1);
        send_frame(31, -1, 1'b0, 0, -1, 6); wait_drain("runt");

        build_frame(3, 1'b0); expect_frame(1'b1);
        send_frame(31, -1, 1'b0, 0, -1, 6); wait_drain("tiny");

        build_frame(60, 1'b1); expect_frame(1'b0);
        send_frame(31, -1, 1'b1, 0, -1, 6); wait_drain("toggle_fcs");

        build_frame(60, 1'b1);
        send_frame(3, -1, 1'b0, 0, -1, 6); wait_drain("short_preamble");

        build_frame(60, 1'b1); expect_frame(1'b0);
        send_frame(31, -1, 1'b0, 0, -1, 6); wait_drain("after_short");

        build_frame(1600, 1'b0); expect_frame(1'b1);
        send_frame(31, -1, 1'b0, 0, -1, 6); wait_drain("oversize");

        build_frame(96, 1'b1);
        for (int k = 0; k < 15; k++) exp_q.push_back({tx_q[k], 1'b0, 1'b0});
        send_frame(31, -1, 1'b0, 0, 20, 2); wait_drain("reset_frame");

        build_frame(60, 1'b1); expect_frame(1'b0);
        send_frame(31, -1, 1'b0, 0, -1, 6); wait_drain("after_reset");

        done = 1'b1;
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
